// File: rtl/rope_gfx_pkg.sv
// Shared types and constants for the rope display pixel path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rope_gfx_pkg;

  localparam int COORD_W = 10;
  // Squared distances carry two extra bits of signed headroom per axis.
  localparam int DY2_W   = 2 * (COORD_W + 2);

  localparam logic [2:0] RGB_BLACK = 3'b000;

  // One entry of the per-line active list.
  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [DY2_W-1:0]   dy2;
  } slot_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } scan_state_t;

endpackage

// File: rtl/node_line_scanner.sv
// Per-line scanner: during horizontal blank, collects the nodes touching the next line.
// Latency: N_NODES+1 cycles per scan; line_overflow is a registered pulse after DONE.
// Backpressure: none; one node tested per clk, the list write always succeeds or flags overflow.
module node_line_scanner #(
  parameter int N_NODES    = 20,
  parameter int COORD_W    = 10,
  parameter int RADIUS     = 5,
  parameter int MAX_ACTIVE = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [COORD_W-1:0]         pix_x,
  input  logic [COORD_W-1:0]         pix_y,
  input  logic [N_NODES*COORD_W-1:0] snap_x,
  input  logic [N_NODES*COORD_W-1:0] snap_y,
  input  logic                       swap,
  output rope_gfx_pkg::slot_t        pend_list [MAX_ACTIVE],
  output logic                       line_overflow
);
  import rope_gfx_pkg::*;

  localparam int IDX_W = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam int CNT_W = $clog2(MAX_ACTIVE + 1);
  localparam logic signed [COORD_W+1:0] RAD_S = (COORD_W+2)'(RADIUS);
  localparam logic [DY2_W-1:0] R2 = DY2_W'(RADIUS * RADIUS);

  scan_state_t state, state_nxt;

  logic                      hend_q;
  logic                      at_hend;
  logic                      start;
  logic [IDX_W-1:0]          idx;
  logic                      last;
  logic [COORD_W-1:0]        ny;
  logic [COORD_W-1:0]        ny_c;
  logic                      ovf;
  logic                      ovf_set;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_nxt;
  logic [CNT_W-1:0]          base_cnt;
  logic [COORD_W-1:0]        sx_arr [N_NODES];
  logic [COORD_W-1:0]        sy_arr [N_NODES];
  logic signed [COORD_W+1:0] dy;
  logic signed [DY2_W-1:0]   dye;
  logic signed [DY2_W-1:0]   sq;
  logic [DY2_W-1:0]          dy2_c;
  logic                      qualify;
  slot_t                     new_slot;
  slot_t                     pend_nxt [MAX_ACTIVE];

  for (genvar i = 0; i < N_NODES; i++) begin : g_unpack
    assign sx_arr[i] = snap_x[i*COORD_W +: COORD_W];
    assign sy_arr[i] = snap_y[i*COORD_W +: COORD_W];
  end

  // A scan is launched by the first cycle of the horizontal blank.
  assign at_hend = (pix_x == COORD_W'(H_ACTIVE));
  assign start   = at_hend & ~hend_q;
  assign ny_c    = (pix_y == COORD_W'(V_TOTAL - 1)) ? '0 : pix_y + COORD_W'(1);
  assign last    = (idx == IDX_W'(N_NODES - 1));

  // Vertical distance from the node centre to the next line.
  assign dy      = $signed({2'b00, sy_arr[idx]}) + RAD_S - $signed({2'b00, ny});
  assign dye     = {{(DY2_W-COORD_W-2){dy[COORD_W+1]}}, dy};
  assign sq      = dye * dye;
  assign dy2_c   = $unsigned(sq);
  // Lines outside the visible area always get an empty list.
  assign qualify = (state == S_SCAN) && (dy2_c <= R2) && (ny < COORD_W'(V_ACTIVE));

  assign new_slot.valid = 1'b1;
  assign new_slot.x     = sx_arr[idx];
  assign new_slot.dy2   = dy2_c;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: IDLE -> SCAN on blank start, SCAN for every node, DONE for one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SCAN;
      S_SCAN:  if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pending list update; a swap clears the list first so a same-cycle write lands in slot 0.
  always_comb begin
    for (int k = 0; k < MAX_ACTIVE; k++) pend_nxt[k] = swap ? '0 : pend_list[k];
    base_cnt = swap ? '0 : cnt;
    cnt_nxt  = base_cnt;
    ovf_set  = 1'b0;
    if (qualify) begin
      if (base_cnt < CNT_W'(MAX_ACTIVE)) begin
        for (int k = 0; k < MAX_ACTIVE; k++) begin
          if (CNT_W'(k) == base_cnt) pend_nxt[k] = new_slot;
        end
        cnt_nxt = base_cnt + CNT_W'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  // Scan datapath: node index, target line, list contents and overflow pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hend_q        <= 1'b0;
      idx           <= '0;
      ny            <= '0;
      ovf           <= 1'b0;
      cnt           <= '0;
      line_overflow <= 1'b0;
      for (int k = 0; k < MAX_ACTIVE; k++) pend_list[k] <= '0;
    end else begin
      hend_q        <= at_hend;
      line_overflow <= (state == S_DONE) && ovf;
      if (state == S_IDLE && start) begin
        ny  <= ny_c;
        idx <= '0;
        ovf <= 1'b0;
      end else begin
        if (state == S_SCAN) idx <= idx + IDX_W'(1);
        if (ovf_set)         ovf <= 1'b1;
      end
      cnt <= cnt_nxt;
      for (int k = 0; k < MAX_ACTIVE; k++) pend_list[k] <= pend_nxt[k];
    end
  end

endmodule

// File: rtl/rope_node_renderer.sv
// Rope pixel colouring: frame snapshot, per-line active list, 2-stage distance/colour pipeline.
// Latency: graph_rgb lags pix_x/pix_y/video_on by exactly 2 clk cycles.
// Backpressure: none; accepts one pixel per clk, free-running.
module rope_node_renderer #(
  parameter int N_NODES    = 20,
  parameter int COORD_W    = 10,
  parameter int RADIUS     = 5,
  parameter int MAX_ACTIVE = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       video_on,
  input  logic [COORD_W-1:0]         pix_x,
  input  logic [COORD_W-1:0]         pix_y,
  input  logic [N_NODES*COORD_W-1:0] nodes_x,
  input  logic [N_NODES*COORD_W-1:0] nodes_y,
  input  logic                       ring_mode,
  input  logic [2:0]                 bg_rgb,
  input  logic [2:0]                 node_rgb,
  input  logic [2:0]                 overlap_rgb,
  output logic [2:0]                 graph_rgb,
  output logic                       line_overflow
);
  import rope_gfx_pkg::*;

  localparam int D2_W = DY2_W + 1;
  localparam logic signed [COORD_W+1:0] RAD_S = (COORD_W+2)'(RADIUS);
  localparam logic [D2_W-1:0] R2  = D2_W'(RADIUS * RADIUS);
  localparam logic [D2_W-1:0] RI2 = D2_W'((RADIUS - 1) * (RADIUS - 1));

  logic [N_NODES*COORD_W-1:0] snap_x;
  logic [N_NODES*COORD_W-1:0] snap_y;
  logic                       snap_cond;
  logic                       snap_q;
  logic [COORD_W-1:0]         pix_y_q;
  logic                       swap;
  slot_t                      pend_list   [MAX_ACTIVE];
  slot_t                      active_list [MAX_ACTIVE];
  slot_t                      cur_list    [MAX_ACTIVE];
  logic [D2_W-1:0]            d2_c [MAX_ACTIVE];
  logic [D2_W-1:0]            d2_q [MAX_ACTIVE];
  logic [MAX_ACTIVE-1:0]      v_q;
  logic                       vid_q;
  logic                       hit_one;
  logic                       hit_multi;
  logic [2:0]                 rgb_c;

  node_line_scanner #(
    .N_NODES    (N_NODES),
    .COORD_W    (COORD_W),
    .RADIUS     (RADIUS),
    .MAX_ACTIVE (MAX_ACTIVE),
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .V_TOTAL    (V_TOTAL)
  ) u_scanner (
    .clk           (clk),
    .reset         (reset),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .snap_x        (snap_x),
    .snap_y        (snap_y),
    .swap          (swap),
    .pend_list     (pend_list),
    .line_overflow (line_overflow)
  );

  assign snap_cond = (pix_y == COORD_W'(V_ACTIVE)) && (pix_x == '0);
  assign swap      = (pix_y != pix_y_q);

  // Latch node coordinates once at the start of vertical blank; track line changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_x  <= '0;
      snap_y  <= '0;
      snap_q  <= 1'b0;
      pix_y_q <= '0;
    end else begin
      snap_q  <= snap_cond;
      pix_y_q <= pix_y;
      if (snap_cond && !snap_q) begin
        snap_x <= nodes_x;
        snap_y <= nodes_y;
      end
    end
  end

  // On the first pixel of a new line the pending list is used directly, so no pixel sees a stale list.
  always_comb begin
    for (int k = 0; k < MAX_ACTIVE; k++) cur_list[k] = swap ? pend_list[k] : active_list[k];
  end

  for (genvar k = 0; k < MAX_ACTIVE; k++) begin : g_slot
    logic signed [COORD_W+1:0] dx;
    logic signed [DY2_W-1:0]   dxe;
    logic signed [DY2_W-1:0]   sq;
    assign dx      = $signed({2'b00, cur_list[k].x}) + RAD_S - $signed({2'b00, pix_x});
    assign dxe     = {{(DY2_W-COORD_W-2){dx[COORD_W+1]}}, dx};
    assign sq      = dxe * dxe;
    assign d2_c[k] = {1'b0, $unsigned(sq)} + {1'b0, cur_list[k].dy2};
  end

  // Stage 1: list swap and per-slot squared distance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_q <= 1'b0;
      v_q   <= '0;
      for (int k = 0; k < MAX_ACTIVE; k++) begin
        active_list[k] <= '0;
        d2_q[k]        <= '0;
      end
    end else begin
      vid_q <= video_on;
      for (int k = 0; k < MAX_ACTIVE; k++) begin
        if (swap) active_list[k] <= pend_list[k];
        d2_q[k] <= d2_c[k];
        v_q[k]  <= cur_list[k].valid;
      end
    end
  end

  // Stage 2 combinational: count hits (saturating at two) and pick the colour.
  always_comb begin
    hit_one   = 1'b0;
    hit_multi = 1'b0;
    for (int k = 0; k < MAX_ACTIVE; k++) begin
      if (v_q[k] && (d2_q[k] <= R2) && (!ring_mode || (d2_q[k] > RI2))) begin
        if (hit_one) hit_multi = 1'b1;
        hit_one = 1'b1;
      end
    end
    if (!vid_q)         rgb_c = RGB_BLACK;
    else if (hit_multi) rgb_c = overlap_rgb;
    else if (hit_one)   rgb_c = node_rgb;
    else                rgb_c = bg_rgb;
  end

  // Stage 2 register: output colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) graph_rgb <= RGB_BLACK;
    else       graph_rgb <= rgb_c;
  end

endmodule

// File: tb/tb_rope_node_renderer.sv
// Directed bench for rope_node_renderer: snapshot, scan, pixel colour and overflow.
// Latency: checks colour 2 clk after driving a pixel.
// Backpressure: n/a.
module tb_rope_node_renderer;

  localparam int N  = 20;
  localparam int CW = 10;
  localparam logic [2:0] BG  = 3'b001;
  localparam logic [2:0] NOD = 3'b010;
  localparam logic [2:0] OVL = 3'b100;

  logic              clk;
  logic              reset;
  logic              video_on;
  logic [CW-1:0]     pix_x;
  logic [CW-1:0]     pix_y;
  logic [N*CW-1:0]   nodes_x;
  logic [N*CW-1:0]   nodes_y;
  logic              ring_mode;
  logic [2:0]        bg_rgb;
  logic [2:0]        node_rgb;
  logic [2:0]        overlap_rgb;
  logic [2:0]        graph_rgb;
  logic              line_overflow;

  int checks = 0;
  int errors = 0;
  int ovf_pulses = 0;

  rope_node_renderer dut (
    .clk           (clk),
    .reset         (reset),
    .video_on      (video_on),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .nodes_x       (nodes_x),
    .nodes_y       (nodes_y),
    .ring_mode     (ring_mode),
    .bg_rgb        (bg_rgb),
    .node_rgb      (node_rgb),
    .overlap_rgb   (overlap_rgb),
    .graph_rgb     (graph_rgb),
    .line_overflow (line_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_node(input int i, input int x, input int y);
    nodes_x[i*CW +: CW] = CW'(x);
    nodes_y[i*CW +: CW] = CW'(y);
  endtask

  task automatic all_off();
    for (int i = 0; i < N; i++) set_node(i, 1000, 1000);
  endtask

  task automatic take_snapshot();
    video_on = 1'b0;
    pix_y = CW'(480);
    pix_x = '0;
    tick(2);
    pix_x = CW'(1);
    tick(1);
  endtask

  // Scan line y during its blank, then move to the following line.
  task automatic scan_line(input int y);
    video_on = 1'b0;
    pix_y = CW'(y);
    pix_x = '0;
    tick(2);
    pix_x = CW'(640);
    ovf_pulses = 0;
    repeat (N + 6) begin
      @(negedge clk);
      if (line_overflow) ovf_pulses++;
    end
    pix_x = '0;
    pix_y = (y == 524) ? '0 : CW'(y + 1);
    tick(2);
  endtask

  task automatic probe(input int x, input int y, input logic vid, input string tag, input logic [2:0] exp);
    pix_x = CW'(x);
    pix_y = CW'(y);
    video_on = vid;
    tick(2);
    chk(tag, 32'(graph_rgb), 32'(exp));
    video_on = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ring_mode = 1'b0;
    bg_rgb = BG;
    node_rgb = NOD;
    overlap_rgb = OVL;
    nodes_x = '0;
    nodes_y = '0;
    all_off();
    pix_x = CW'(10);
    pix_y = CW'(10);
    video_on = 1'b1;
    tick(3);
    chk("rst_rgb", 32'(graph_rgb), 32'd0);
    chk("rst_ovf", 32'(line_overflow), 32'd0);
    reset = 1'b0;
    video_on = 1'b0;

    // Nothing in view.
    take_snapshot();
    scan_line(99);
    probe(0, 100, 1'b1, "empty_l", BG);
    probe(105, 100, 1'b1, "empty_m", BG);
    probe(639, 100, 1'b1, "empty_r", BG);

    // Single filled disc and ring.
    set_node(0, 100, 100);
    take_snapshot();
    scan_line(104);
    probe(105, 105, 1'b1, "disc_ctr", NOD);
    probe(110, 105, 1'b1, "disc_edge", NOD);
    probe(111, 105, 1'b1, "disc_out", BG);
    probe(105, 105, 1'b0, "blank_black", 3'b000);
    ring_mode = 1'b1;
    probe(105, 105, 1'b1, "ring_ctr", BG);
    probe(109, 105, 1'b1, "ring_inner", BG);
    probe(110, 105, 1'b1, "ring_edge", NOD);
    ring_mode = 1'b0;
    scan_line(99);
    probe(105, 100, 1'b1, "disc_top", NOD);
    probe(106, 100, 1'b1, "disc_top_out", BG);

    // Two coincident nodes.
    all_off();
    set_node(0, 200, 50);
    set_node(1, 200, 50);
    take_snapshot();
    scan_line(54);
    probe(205, 55, 1'b1, "ovl_ctr", OVL);
    probe(210, 55, 1'b1, "ovl_edge", OVL);
    probe(211, 55, 1'b1, "ovl_out", BG);

    // Nine nodes on line 300: one too many.
    all_off();
    for (int k = 0; k < 9; k++) set_node(k, (k + 1) * 20, 295);
    take_snapshot();
    scan_line(299);
    chk("ovf_pulse", 32'(ovf_pulses), 32'd1);
    for (int k = 0; k < 8; k++) probe((k + 1) * 20 + 5, 300, 1'b1, "ovf_slot", NOD);
    probe(185, 300, 1'b1, "ovf_dropped", BG);
    scan_line(310);
    chk("no_ovf", 32'(ovf_pulses), 32'd0);

    // Moves between snapshots are invisible.
    all_off();
    set_node(0, 100, 100);
    take_snapshot();
    set_node(0, 300, 100);
    scan_line(104);
    probe(105, 105, 1'b1, "snap_old", NOD);
    probe(305, 105, 1'b1, "snap_new_hidden", BG);
    take_snapshot();
    scan_line(104);
    probe(305, 105, 1'b1, "snap_new", NOD);
    probe(105, 105, 1'b1, "snap_old_gone", BG);

    // Vertical boundaries: first invisible line is empty, last line wraps to line 0.
    all_off();
    set_node(0, 100, 475);
    take_snapshot();
    scan_line(479);
    probe(105, 480, 1'b1, "past_vactive", BG);
    set_node(0, 100, 0);
    take_snapshot();
    scan_line(524);
    probe(105, 0, 1'b1, "wrap_top", NOD);

    // Reset in the middle of a scan.
    all_off();
    set_node(0, 100, 100);
    take_snapshot();
    scan_line(99);
    probe(105, 100, 1'b1, "pre_rst", NOD);
    pix_x = '0;
    tick(2);
    pix_x = CW'(640);
    tick(5);
    reset = 1'b1;
    tick(2);
    chk("rst2_rgb", 32'(graph_rgb), 32'd0);
    chk("rst2_ovf", 32'(line_overflow), 32'd0);
    reset = 1'b0;
    pix_x = '0;
    pix_y = CW'(101);
    tick(2);
    probe(105, 101, 1'b1, "post_rst_ctr", BG);
    probe(100, 101, 1'b1, "post_rst_l", BG);
    probe(110, 101, 1'b1, "post_rst_r", BG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
